// File: rtl/cam_search_encoder.sv
// CAM search front end: 32-entry key store, two-stage compare/encode pipeline
// with a valid/ready handshake; the encoded index drives the word-mux select.
module cam_search_encoder #(
   parameter int unsigned ENTRIES = 32,
   parameter int unsigned KEY_W   = 32,
   parameter int unsigned IDX_W   = 5
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             write_v_i,
   input  logic [IDX_W-1:0] write_idx_i,
   input  logic [KEY_W-1:0] write_key_i,
   input  logic             inval_v_i,
   input  logic [IDX_W-1:0] inval_idx_i,
   input  logic             inval_all_i,
   input  logic             search_v_i,
   input  logic [KEY_W-1:0] search_key_i,
   output logic             search_ready_o,
   output logic             result_v_o,
   output logic             result_hit_o,
   output logic [IDX_W-1:0] result_idx_o,
   output logic             result_multi_o,
   input  logic             result_ready_i
);

   localparam logic [ENTRIES-1:0] ONE_VEC = ENTRIES'(1);

   // key storage and per-entry valid bits
   logic [KEY_W-1:0]   key_q [ENTRIES];
   logic [ENTRIES-1:0] valid_q;

   // stage 1: captured match vector
   logic               s1_v_q;
   logic [ENTRIES-1:0] s1_match_q;

   // output register
   logic               out_v_q;
   logic               out_hit_q;
   logic [IDX_W-1:0]   out_idx_q;
   logic               out_multi_q;

   // combinational helpers
   logic               write_en_c;
   logic               accept_c;
   logic               out_load_c;
   logic [ENTRIES-1:0] match_c;
   logic               enc_hit_c;
   logic [IDX_W-1:0]   enc_idx_c;
   logic               enc_multi_c;

   // a write loses to any invalidate of the same index and to invalidate-all
   assign write_en_c = write_v_i && !inval_all_i &&
                       !(inval_v_i && (inval_idx_i == write_idx_i));

   // output register is free when empty or being consumed this edge
   assign out_load_c     = !out_v_q || result_ready_i;
   assign search_ready_o = !s1_v_q || out_load_c;
   assign accept_c       = search_v_i && search_ready_o;

   // key array update; keys are only ever replaced by an accepted write
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            key_q[i] <= '0;
         end
      end else if (write_en_c) begin
         key_q[write_idx_i] <= write_key_i;
      end
   end

   // valid bits: invalidate-all beats single invalidate beats write
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= '0;
      end else if (inval_all_i) begin
         valid_q <= '0;
      end else begin
         if (write_en_c) begin
            valid_q[write_idx_i] <= 1'b1;
         end
         if (inval_v_i) begin
            valid_q[inval_idx_i] <= 1'b0;
         end
      end
   end

   // parallel compare against pre-update storage
   always_comb begin
      match_c = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         match_c[i] = valid_q[i] && (key_q[i] == search_key_i);
      end
   end

   // stage 1 register; when full it can only be refilled as it drains
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         s1_v_q     <= 1'b0;
         s1_match_q <= '0;
      end else if (accept_c) begin
         s1_v_q     <= 1'b1;
         s1_match_q <= match_c;
      end else if (out_load_c) begin
         s1_v_q     <= 1'b0;
      end
   end

   // priority encode: lowest set bit, hit flag and more-than-one flag
   always_comb begin
      enc_hit_c   = 1'b0;
      enc_idx_c   = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (s1_match_q[i] && !enc_hit_c) begin
            enc_hit_c = 1'b1;
            enc_idx_c = IDX_W'(i);
         end
      end
      // clearing the lowest set bit leaves something only if two or more were set
      enc_multi_c = (s1_match_q & (s1_match_q - ONE_VEC)) != '0;
   end

   // output register; holds everything while stalled
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         out_v_q     <= 1'b0;
         out_hit_q   <= 1'b0;
         out_idx_q   <= '0;
         out_multi_q <= 1'b0;
      end else if (out_load_c) begin
         out_v_q <= s1_v_q;
         if (s1_v_q) begin
            out_hit_q   <= enc_hit_c;
            out_idx_q   <= enc_idx_c;
            out_multi_q <= enc_multi_c;
         end
      end
   end

   assign result_v_o     = out_v_q;
   assign result_hit_o   = out_hit_q;
   assign result_idx_o   = out_idx_q;
   assign result_multi_o = out_multi_q;

endmodule
